instruction_fetch_unit: RTL and testbench

- Upstream stage of the immediate path. Owns the PC and issues word fetches to instruction memory over a request/ready handshake.
- Registers the returned instruction and splits it into fields. immediateOut[15:0] feeds the sign extender directly; opcode/rs/rt/rd/funct feed control and the register file.
- Supports decode stall and branch/jump redirect (flush).

---
 rtl/instruction_fetch_unit_pkg.sv | 27 ++
 rtl/instruction_field_splitter.sv | 21 ++
 rtl/instruction_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, fetch FSM encodings and instruction field positions for the
// fetch unit and the decode logic downstream of it.
package instruction_fetch_unit_pkg;

  localparam int WORD_LEN        = 32;
  localparam int SIGN_EXTEND_LEN = 16;

  typedef enum logic [1:0] {
    FETCH_START   = 2'd0,
    FETCH_REQUEST = 2'd1,
    FETCH_HOLD    = 2'd2
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

endpackage

// File: rtl/instruction_field_splitter.sv
// Pure-wiring split of a 32-bit instruction word into its decode fields.
module instruction_field_splitter
  import instruction_fetch_unit_pkg::*;
(
  input  logic [WORD_LEN-1:0]        instr,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [5:0]                 funct,
  output logic [SIGN_EXTEND_LEN-1:0] immediate
);

  assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
  assign rs        = instr[RS_MSB:RS_LSB];
  assign rt        = instr[RT_MSB:RT_LSB];
  assign rd        = instr[RD_MSB:RD_LSB];
  assign funct     = instr[FUNCT_MSB:FUNCT_LSB];
  assign immediate = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over a request/ready handshake and
// registers the returned word, with decode stall and redirect (flush) support.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [WORD_LEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_LEN-1:0] PC_STEP  = 32'd4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirectValid,
  input  logic [WORD_LEN-1:0]        redirectTarget,
  output logic                       memRequest,
  output logic [WORD_LEN-1:0]        memAddress,
  input  logic                       memReady,
  input  logic [WORD_LEN-1:0]        memData,
  output logic                       instructionValid,
  output logic [WORD_LEN-1:0]        instructionOut,
  output logic [WORD_LEN-1:0]        pcOut,
  output logic [WORD_LEN-1:0]        pcPlus4Out,
  output logic [5:0]                 opcodeOut,
  output logic [4:0]                 rsOut,
  output logic [4:0]                 rtOut,
  output logic [4:0]                 rdOut,
  output logic [5:0]                 functOut,
  output logic [SIGN_EXTEND_LEN-1:0] immediateOut
);

  fetch_state_e        state_q, state_d;
  logic [WORD_LEN-1:0] pc_q, pc_d;
  logic                pend_q, pend_d;
  logic [WORD_LEN-1:0] pend_target_q, pend_target_d;
  logic [WORD_LEN-1:0] hold_instr_q, hold_instr_d;
  logic [WORD_LEN-1:0] hold_pc_q, hold_pc_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_LEN-1:0] out_instr_q, out_instr_d;
  logic [WORD_LEN-1:0] out_pc_q, out_pc_d;
  logic [WORD_LEN-1:0] out_pc4_q, out_pc4_d;
  logic [WORD_LEN-1:0] pc_next_seq;

  assign pc_next_seq = pc_q + PC_STEP;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FETCH_START;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      out_pc4_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      out_pc4_q     <= out_pc4_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    out_pc4_d     = out_pc4_q;
    out_valid_d   = stall ? out_valid_q : 1'b0;

    case (state_q)
      FETCH_START: begin
        state_d = FETCH_REQUEST;
        if (redirectValid) pc_d = redirectTarget;
      end
      FETCH_REQUEST: begin
        if (memReady) begin
          // A response that crosses a redirect is stale and must be dropped.
          if (redirectValid) begin
            pc_d   = redirectTarget;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = pend_target_q;
            pend_d = 1'b0;
          end else if (!stall) begin
            out_instr_d = memData;
            out_pc_d    = pc_q;
            out_pc4_d   = pc_next_seq;
            out_valid_d = 1'b1;
            pc_d        = pc_next_seq;
          end else begin
            hold_instr_d = memData;
            hold_pc_d    = pc_q;
            pc_d         = pc_next_seq;
            state_d      = FETCH_HOLD;
          end
        end else if (redirectValid) begin
          pend_d        = 1'b1;
          pend_target_d = redirectTarget;
        end
      end
      FETCH_HOLD: begin
        if (redirectValid) begin
          pc_d    = redirectTarget;
          state_d = FETCH_REQUEST;
        end else if (!stall) begin
          out_instr_d = hold_instr_q;
          out_pc_d    = hold_pc_q;
          out_pc4_d   = hold_pc_q + PC_STEP;
          out_valid_d = 1'b1;
          state_d     = FETCH_REQUEST;
        end
      end
      default: state_d = FETCH_START;
    endcase

    if (redirectValid) out_valid_d = 1'b0;
  end

  assign memRequest       = (state_q == FETCH_REQUEST);
  assign memAddress       = pc_q;
  assign instructionValid = out_valid_q;
  assign instructionOut   = out_instr_q;
  assign pcOut            = out_pc_q;
  assign pcPlus4Out       = out_pc4_q;

  instruction_field_splitter u_splitter (
    .instr     (out_instr_q),
    .opcode    (opcodeOut),
    .rs        (rsOut),
    .rt        (rtOut),
    .rd        (rdOut),
    .funct     (functOut),
    .immediate (immediateOut)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed walk through the fetch scenarios followed by randomized traffic,
// all compared cycle by cycle against a behavioural fetch model.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, stall, redirectValid, memReady;
  logic [31:0] redirectTarget, memData;
  logic        memRequest, instructionValid;
  logic [31:0] memAddress, instructionOut, pcOut, pcPlus4Out;
  logic [5:0]  opcodeOut, functOut;
  logic [4:0]  rsOut, rtOut, rdOut;
  logic [15:0] immediateOut;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  bit          m_startup, m_parked, m_pend, m_v;
  logic [31:0] m_pc, m_pend_tgt, m_buf_i, m_buf_pc, m_instr, m_opc, m_opc4;

  always #5 clock = ~clock;

  instruction_fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget),
    .memRequest(memRequest), .memAddress(memAddress),
    .memReady(memReady), .memData(memData),
    .instructionValid(instructionValid), .instructionOut(instructionOut),
    .pcOut(pcOut), .pcPlus4Out(pcPlus4Out),
    .opcodeOut(opcodeOut), .rsOut(rsOut), .rtOut(rtOut), .rdOut(rdOut),
    .functOut(functOut), .immediateOut(immediateOut)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Next-cycle behaviour of the fetch unit, derived from the fetch rules.
  task automatic model_step(input bit r, input bit rdy, input bit stl, input bit rv,
                            input logic [31:0] tgt, input logic [31:0] dat);
    bit nv;
    if (r) begin
      m_pc = 32'h0; m_startup = 1; m_parked = 0; m_pend = 0; m_pend_tgt = 0;
      m_buf_i = 0; m_buf_pc = 0; m_v = 0; m_instr = 0; m_opc = 0; m_opc4 = 0;
      return;
    end
    nv = stl ? m_v : 1'b0;
    if (m_startup) begin
      m_startup = 0;
      if (rv) m_pc = tgt;
    end else if (m_parked) begin
      if (rv) begin
        m_pc = tgt; m_parked = 0;
      end else if (!stl) begin
        m_instr = m_buf_i; m_opc = m_buf_pc; m_opc4 = m_buf_pc + 32'd4;
        nv = 1; m_parked = 0;
      end
    end else if (rdy) begin
      if (rv) begin
        m_pc = tgt; m_pend = 0;
      end else if (m_pend) begin
        m_pc = m_pend_tgt; m_pend = 0;
      end else if (!stl) begin
        m_instr = dat; m_opc = m_pc; m_opc4 = m_pc + 32'd4; nv = 1;
        m_pc = m_pc + 32'd4;
      end else begin
        m_buf_i = dat; m_buf_pc = m_pc; m_pc = m_pc + 32'd4; m_parked = 1;
      end
    end else if (rv) begin
      m_pend = 1; m_pend_tgt = tgt;
    end
    if (rv) nv = 0;
    m_v = nv;
  endtask

  task automatic compare_all();
    check("memRequest", {31'b0, memRequest}, {31'b0, !m_startup && !m_parked});
    check("memAddress", memAddress, m_pc);
    check("instructionValid", {31'b0, instructionValid}, {31'b0, m_v});
    check("instructionOut", instructionOut, m_instr);
    check("pcOut", pcOut, m_opc);
    check("pcPlus4Out", pcPlus4Out, m_opc4);
    check("opcodeOut", {26'b0, opcodeOut}, m_instr >> 26);
    check("rsOut", {27'b0, rsOut}, (m_instr >> 21) & 32'h1f);
    check("rtOut", {27'b0, rtOut}, (m_instr >> 16) & 32'h1f);
    check("rdOut", {27'b0, rdOut}, (m_instr >> 11) & 32'h1f);
    check("functOut", {26'b0, functOut}, m_instr & 32'h3f);
    check("immediateOut", {16'b0, immediateOut}, m_instr & 32'hffff);
  endtask

  task automatic cyc(input bit r, input bit rdy, input bit stl, input bit rv,
                     input logic [31:0] tgt, input logic [31:0] dat);
    reset = r; memReady = rdy; stall = stl; redirectValid = rv;
    redirectTarget = tgt; memData = dat;
    model_step(r, rdy, stl, rv, tgt, dat);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  initial begin
    bit r, rdy, stl, rv;
    logic [31:0] tgt;

    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_memRequest", {31'b0, memRequest}, 32'd0);
    check("rst_valid", {31'b0, instructionValid}, 32'd0);
    check("rst_pcOut", pcOut, 32'd0);

    // First fetch: START cycle then REQUEST at address 0
    cyc(0, 1, 0, 0, 0, 32'h2008_8000);
    check("first_req", {31'b0, memRequest}, 32'd1);
    check("first_addr", memAddress, 32'h0);
    cyc(0, 1, 0, 0, 0, 32'h2008_8000);
    check("first_valid", {31'b0, instructionValid}, 32'd1);
    check("first_opcode", {26'b0, opcodeOut}, 32'h08);
    check("first_rt", {27'b0, rtOut}, 32'd8);
    check("first_imm", {16'b0, immediateOut}, 32'h8000);
    check("first_pc4", pcPlus4Out, 32'd4);
    cyc(0, 1, 0, 0, 0, 32'h8C22_0004);
    check("second_pc", pcOut, 32'd4);

    // Stall at delivery of the word at pc 8 parks it in the hold buffer
    cyc(0, 1, 1, 0, 0, 32'h0000_7FFF);
    check("hold_req", {31'b0, memRequest}, 32'd0);
    check("hold_frozen_pc", pcOut, 32'd4);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("hold_frozen_valid", {31'b0, instructionValid}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    check("unhold_imm", {16'b0, immediateOut}, 32'h7FFF);
    check("unhold_pc", pcOut, 32'd8);
    check("unhold_addr", memAddress, 32'hC);

    // Back-to-back fetches
    for (int i = 0; i < 4; i++) begin
      check("b2b_addr", memAddress, 32'hC + 32'(4 * i));
      cyc(0, 1, 0, 0, 0, $urandom);
      check("b2b_valid", {31'b0, instructionValid}, 32'd1);
      check("b2b_pc", pcOut, 32'hC + 32'(4 * i));
    end

    // Redirect while waiting on memory: response discarded
    cyc(0, 0, 0, 1, 32'h100, 0);
    check("wait_addr_held", memAddress, 32'h1C);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("wait_addr_held2", memAddress, 32'h1C);
    cyc(0, 1, 0, 0, 0, 32'hDEAD_BEEF);
    check("discard_valid", {31'b0, instructionValid}, 32'd0);
    check("redir_addr", memAddress, 32'h100);
    cyc(0, 1, 0, 0, 0, 32'h0123_4567);
    check("redir_pc", pcOut, 32'h100);

    // Redirect while holding drops the buffer
    cyc(0, 1, 1, 0, 0, 32'hCAFE_F00D);
    cyc(0, 0, 1, 1, 32'h40, 0);
    check("holdredir_valid", {31'b0, instructionValid}, 32'd0);
    check("holdredir_addr", memAddress, 32'h40);
    check("holdredir_req", {31'b0, memRequest}, 32'd1);

    // PC wrap
    cyc(0, 1, 0, 1, 32'hFFFF_FFFC, 0);
    check("wrap_target", memAddress, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0, 0, 32'h1111_2222);
    check("wrap_addr", memAddress, 32'h0);
    check("wrap_pc4", pcPlus4Out, 32'h0);

    // Reset in the middle of a request
    cyc(1, 1, 0, 0, 0, 32'h3333_4444);
    check("midrst_req", {31'b0, memRequest}, 32'd0);
    check("midrst_instr", instructionOut, 32'h0);
    check("midrst_valid", {31'b0, instructionValid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      cyc(r, rdy, stl, rv, tgt, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
